// File: rtl/octant_bbox_calc_if.sv
// octant_bbox_calc_if
//   Bundles the control, BRAM read and result signals of octant_bbox_calc.
//   slave  : the bounding-box block itself (consumes i_*, drives o_*)
//   master : whatever drives it (controller or testbench)
//   Signals:
//     i_en, i_start, i_point_cloud_size  - scan control
//     o_rd_en, o_rd_addr, i_rd_data      - BRAM read port (data 1 cycle after o_rd_en)
//     o_near_bottom_left, o_far_top_right, o_mid_point - packed x,y,z,pad results
//     o_busy, o_done                     - status
interface octant_bbox_calc_if #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned ADDR_W  = 16
);
  logic                   i_en;
  logic                   i_start;
  logic [ADDR_W-1:0]      i_point_cloud_size;
  logic                   o_rd_en;
  logic [ADDR_W-1:0]      o_rd_addr;
  logic [4*COORD_W-1:0]   i_rd_data;
  logic [4*COORD_W-1:0]   o_near_bottom_left;
  logic [4*COORD_W-1:0]   o_far_top_right;
  logic [4*COORD_W-1:0]   o_mid_point;
  logic                   o_busy;
  logic                   o_done;

  modport slave (
    input  i_en, i_start, i_point_cloud_size, i_rd_data,
    output o_rd_en, o_rd_addr, o_near_bottom_left, o_far_top_right,
           o_mid_point, o_busy, o_done
  );

  modport master (
    output i_en, i_start, i_point_cloud_size, i_rd_data,
    input  o_rd_en, o_rd_addr, o_near_bottom_left, o_far_top_right,
           o_mid_point, o_busy, o_done
  );
endinterface

// File: rtl/octant_bbox_calc.sv
// octant_bbox_calc
//   Scans N packed points from BRAM (one read per enabled cycle), tracks the
//   signed per-axis min/max and derives the floor midpoint. Results are
//   registered on entry to DONE and o_done pulses one cycle later.
//   Ports:
//     i_clk   - clock
//     i_rst_n - asynchronous active-low reset
//     bus     - octant_bbox_calc_if.slave (control, BRAM read port, results)
module octant_bbox_calc #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  octant_bbox_calc_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    MID,
    DONE
  } state_t;

  state_t                      state;
  logic [ADDR_W-1:0]           n_pts;
  logic [ADDR_W-1:0]           cnt;
  logic                        rd_pend;
  logic                        have_pt;

  // Index 0 = x, 1 = y, 2 = z
  logic signed [COORD_W-1:0]   pt [3];
  logic signed [COORD_W-1:0]   mn [3];
  logic signed [COORD_W-1:0]   mx [3];
  logic        [COORD_W-1:0]   md [3];

  assign pt[0] = bus.i_rd_data[4*COORD_W-1 -: COORD_W];
  assign pt[1] = bus.i_rd_data[3*COORD_W-1 -: COORD_W];
  assign pt[2] = bus.i_rd_data[2*COORD_W-1 -: COORD_W];

  // Sum in COORD_W+1 bits; dropping bit 0 is the arithmetic shift, so the
  // result is floor((a+b)/2) and always fits back in COORD_W.
  function automatic logic [COORD_W-1:0] mid_of(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {a[COORD_W-1], a} + {b[COORD_W-1], b};
    return s[COORD_W:1];
  endfunction

  always_comb begin
    md[0] = mid_of(mn[0], mx[0]);
    md[1] = mid_of(mn[1], mx[1]);
    md[2] = mid_of(mn[2], mx[2]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                  <= IDLE;
      n_pts                  <= '0;
      cnt                    <= '0;
      rd_pend                <= 1'b0;
      have_pt                <= 1'b0;
      bus.o_rd_en            <= 1'b0;
      bus.o_rd_addr          <= '0;
      bus.o_busy             <= 1'b0;
      bus.o_done             <= 1'b0;
      bus.o_near_bottom_left <= '0;
      bus.o_far_top_right    <= '0;
      bus.o_mid_point        <= '0;
      for (int unsigned a = 0; a < 3; a++) begin
        mn[a] <= '0;
        mx[a] <= '0;
      end
    end else begin
      rd_pend    <= bus.o_rd_en;
      bus.o_done <= 1'b0;

      // Read data is absorbed independently of i_en so an in-flight read
      // issued just before a pause is never dropped.
      if (rd_pend) begin
        have_pt <= 1'b1;
        for (int unsigned a = 0; a < 3; a++) begin
          if (!have_pt || (pt[a] < mn[a])) mn[a] <= pt[a];
          if (!have_pt || (pt[a] > mx[a])) mx[a] <= pt[a];
        end
      end

      case (state)
        IDLE: begin
          bus.o_rd_en <= 1'b0;
          if (bus.i_en && bus.i_start) begin
            n_pts      <= bus.i_point_cloud_size;
            cnt        <= '0;
            have_pt    <= 1'b0;
            bus.o_busy <= 1'b1;
            if (bus.i_point_cloud_size == '0) begin
              bus.o_near_bottom_left <= '0;
              bus.o_far_top_right    <= '0;
              bus.o_mid_point        <= '0;
              state                  <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          if (bus.i_en) begin
            bus.o_rd_en   <= 1'b1;
            bus.o_rd_addr <= cnt;
            cnt           <= cnt + 1'b1;
            if (cnt == n_pts - 1'b1) state <= DRAIN;
          end else begin
            bus.o_rd_en <= 1'b0;
          end
        end

        DRAIN: begin
          bus.o_rd_en <= 1'b0;
          // Final read is pending once the strobe has dropped and rd_pend is high
          if (rd_pend && !bus.o_rd_en) state <= MID;
        end

        MID: begin
          bus.o_near_bottom_left <= {mn[0], mn[1], mn[2], {COORD_W{1'b0}}};
          bus.o_far_top_right    <= {mx[0], mx[1], mx[2], {COORD_W{1'b0}}};
          bus.o_mid_point        <= {md[0], md[1], md[2], {COORD_W{1'b0}}};
          state                  <= DONE;
        end

        DONE: begin
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
